// File: rtl/rf_write_arbiter.sv
// Two-requester (ALU/LSU) register-file write arbiter with round-robin conflict resolution.
// Optional conflict statistics counter enabled by defining RF_WARB_STATS_EN.
module rf_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [WIDTH-1:0]  alu_wdata,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [WIDTH-1:0]  lsu_wdata,
  output logic              alu_ready,
  output logic              lsu_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic RR_ALU = 1'b0;
  localparam logic RR_LSU = 1'b1;

  logic              r_rr_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [WIDTH-1:0]  r_wdata;

  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_conflict;
  logic              w_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WIDTH-1:0]  w_sel_data;

  assign w_conflict = !hold && alu_valid && lsu_valid;

  // Grants are suppressed during reset so nothing is consumed that reset would discard.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!rst && !hold) begin
      if (alu_valid && lsu_valid) begin
        if (r_rr_last == RR_LSU) w_alu_gnt = 1'b1;
        else                     w_lsu_gnt = 1'b1;
      end else begin
        w_alu_gnt = alu_valid;
        w_lsu_gnt = lsu_valid;
      end
    end
  end

  assign w_sel_addr = w_lsu_gnt ? lsu_waddr : alu_waddr;
  assign w_sel_data = w_lsu_gnt ? lsu_wdata : alu_wdata;
  // Register 0 is hardwired: the request is consumed but never written.
  assign w_wr       = (w_alu_gnt || w_lsu_gnt) && (w_sel_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rr_last <= RR_LSU;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
      if (w_alu_gnt)      r_rr_last <= RR_ALU;
      else if (w_lsu_gnt) r_rr_last <= RR_LSU;
    end
  end

`ifdef RF_WARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  logic w_unused;
  assign w_unused     = w_conflict;
  assign conflict_cnt = 16'h0000;
`endif

  assign alu_ready    = w_alu_gnt;
  assign lsu_ready    = w_lsu_gnt;
  // A write registered just before reset rises is masked while reset is active.
  assign write_enable = r_we && !rst;
  assign waddr        = r_waddr;
  assign wdata        = r_wdata;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed steps push expected outputs,
// a negedge monitor pops and compares them.
module tb_rf_write_arbiter;

`ifdef RF_WARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_waddr, lsu_waddr;
  logic [31:0] alu_wdata, lsu_wdata;
  logic        alu_ready, lsu_ready, write_enable;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ar;
    logic        lr;
    logic        we;
    logic        chk_addr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  rf_write_arbiter #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .alu_ready(alu_ready), .lsu_ready(lsu_ready),
    .write_enable(write_enable), .waddr(waddr), .wdata(wdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] c(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the outputs expected to be visible during that cycle.
  task automatic step(input logic r, input logic h,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic ear, input logic elr, input logic ewe,
                      input logic eca, input logic [4:0] eaddr, input logic [31:0] edata,
                      input logic ecc, input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hold = h;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    e.ar = ear; e.lr = elr; e.we = ewe; e.chk_addr = eca;
    e.addr = eaddr; e.data = edata; e.chk_cnt = ecc; e.cnt = ecnt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("alu_ready", 32'(alu_ready), 32'(e.ar));
      chk("lsu_ready", 32'(lsu_ready), 32'(e.lr));
      chk("write_enable", 32'(write_enable), 32'(e.we));
      if (e.chk_addr) begin
        chk("waddr", 32'(waddr), 32'(e.addr));
        chk("wdata", wdata, e.data);
      end
      if (e.chk_cnt) chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;

    //    rst hold av aa  ad            lv la  ld        ar lr we ca addr data          cc cnt
    step(1, 0,   0, 0,  0,            0, 0,  0,        0, 0, 0, 0, 0,   0,            0, 0);
    step(1, 0,   0, 0,  0,            0, 0,  0,        0, 0, 0, 1, 0,   0,            1, 0);
    // single ALU write
    step(0, 0,   1, 5,  32'hDEADBEEF, 0, 0,  0,        1, 0, 0, 1, 0,   0,            1, 0);
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 1, 1, 5,   32'hDEADBEEF, 1, 0);
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 0, 1, 5,   32'hDEADBEEF, 1, 0);
    // single LSU write leaves rr_last at LSU
    step(0, 0,   0, 0,  0,            1, 3,  32'h33,   0, 1, 0, 1, 5,   32'hDEADBEEF, 1, 0);
    // sustained conflict alternates ALU, LSU, ALU, LSU
    step(0, 0,   1, 1,  32'h11,       1, 2,  32'h22,   1, 0, 1, 1, 3,   32'h33,       1, c(0));
    step(0, 0,   1, 1,  32'h11,       1, 2,  32'h22,   0, 1, 1, 1, 1,   32'h11,       1, c(1));
    step(0, 0,   1, 1,  32'h11,       1, 2,  32'h22,   1, 0, 1, 1, 2,   32'h22,       1, c(2));
    step(0, 0,   1, 1,  32'h11,       1, 2,  32'h22,   0, 1, 1, 1, 1,   32'h11,       1, c(3));
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 1, 1, 2,   32'h22,       1, c(4));
    // LSU write to register 0 is consumed without a write strobe
    step(0, 0,   0, 0,  0,            1, 0,  32'h1234, 0, 1, 0, 1, 2,   32'h22,       1, c(4));
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 0, 0, 0,   0,            1, c(4));
    // hold blocks grants and counting; ALU wins on release
    step(0, 1,   1, 1,  32'h11,       1, 2,  32'h22,   0, 0, 0, 0, 0,   0,            1, c(4));
    step(0, 1,   1, 1,  32'h11,       1, 2,  32'h22,   0, 0, 0, 0, 0,   0,            1, c(4));
    step(0, 1,   1, 1,  32'h11,       1, 2,  32'h22,   0, 0, 0, 0, 0,   0,            1, c(4));
    step(0, 0,   1, 1,  32'h11,       1, 2,  32'h22,   1, 0, 0, 0, 0,   0,            1, c(4));
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 1, 1, 1,   32'h11,       1, c(5));
    // ALU grant immediately followed by reset is discarded
    step(0, 0,   1, 7,  32'h77,       0, 0,  0,        1, 0, 0, 1, 1,   32'h11,       1, c(5));
    step(1, 0,   1, 9,  32'h99,       0, 0,  0,        0, 0, 0, 0, 0,   0,            1, c(5));
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 0, 1, 0,   0,            1, 0);
    step(0, 0,   1, 1,  32'h11,       1, 2,  32'h22,   1, 0, 0, 1, 0,   0,            1, 0);
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 1, 1, 1,   32'h11,       1, c(1));
    // hold with a single requester
    step(0, 1,   1, 4,  32'h44,       0, 0,  0,        0, 0, 0, 1, 1,   32'h11,       1, c(1));
    step(0, 0,   0, 0,  0,            0, 0,  0,        0, 0, 0, 1, 1,   32'h11,       1, c(1));

    if (STATS) begin
      for (int i = 0; i < 65540; i++) begin
        @(posedge clk);
        #1;
        rst = 1'b0; hold = 1'b0;
        alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h11;
        lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h22;
      end
      step(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 16'hFFFF);
      step(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 16'hFFFF);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
